// File: rtl/exp_golomb_stream_decoder.sv
// Exp-Golomb syntax-element decoder.
// Input words are packed MSB-first into a bit buffer whose bit 0 is the next
// stream bit. One command at a time decodes ue(v), se(v), te(v) or u(n) from
// the head of the buffer and consumes exactly the codeword length.
//
// Handshakes (input, command, result): a transfer happens on a rising clk edge
// where both valid and ready are high. A producer holds valid and its payload
// stable until the transfer. The result side holds res_valid/res_data/res_len/
// res_err stable until res_ready is seen; res_valid drops the following cycle.
module exp_golomb_stream_decoder #(
    parameter int IN_W     = 16,
    parameter int BUF_BITS = 64,
    parameter int MAX_LZ   = 15,
    parameter int OUT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [4:0]       cmd_arg,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OUT_W-1:0] res_data,
    output logic [5:0]       res_len,
    output logic             res_err,
    output logic [6:0]       fill_level,
    output logic [1:0]       fsm_state
);

    // Longest Exp-Golomb codeword and the read window (also covers u(31)).
    localparam int CW  = 2 * MAX_LZ + 1;
    localparam int WIN = (CW > 31) ? CW : 31;
    localparam int LZW = $clog2(MAX_LZ + 2);

    localparam logic [6:0]       PUSH_LIMIT = 7'(BUF_BITS - IN_W);
    localparam logic [6:0]       LZ_WINDOW  = 7'(MAX_LZ + 1);
    localparam logic [6:0]       IN_W7      = 7'(IN_W);
    localparam logic [5:0]       WIN_LEN    = 6'(WIN);
    localparam logic [OUT_W-1:0] ONE        = OUT_W'(1);

    localparam logic [1:0] MODE_UE = 2'd0;
    localparam logic [1:0] MODE_SE = 2'd1;
    localparam logic [1:0] MODE_TE = 2'd2;
    localparam logic [1:0] MODE_U  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t              state_q;
    logic [1:0]          mode_q;
    logic [4:0]          arg_q;
    logic [BUF_BITS-1:0] buf_q;
    logic [BUF_BITS-1:0] buf_next;
    logic [6:0]          fill_q;
    logic [6:0]          fill_next;
    logic [6:0]          fill_after;
    logic [IN_W-1:0]     word_rev;
    logic [WIN-1:0]      stream_win;
    logic [WIN-1:0]      code_val;
    logic [LZW-1:0]      lz;
    logic                one_found;
    logic                exp_form;
    logic [5:0]          need;
    logic                dec_go;
    logic                dec_err;
    logic [5:0]          consume_len;
    logic                push;
    logic [OUT_W-1:0]    ue_val;
    logic [OUT_W-1:0]    se_val;
    logic [OUT_W-1:0]    dec_value;

    assign in_ready   = (fill_q <= PUSH_LIMIT);
    assign push       = in_valid && in_ready;
    assign cmd_ready  = (state_q == IDLE);
    assign fill_level = fill_q;
    assign fsm_state  = state_q;

    // Reverse the incoming word so its first stream bit lands at the lowest index.
    always_comb begin
        for (int i = 0; i < IN_W; i++) begin
            word_rev[i] = in_data[IN_W-1-i];
        end
    end

    // View of the buffer head with the next stream bit as MSB.
    always_comb begin
        for (int i = 0; i < WIN; i++) begin
            stream_win[WIN-1-i] = buf_q[i];
        end
    end

    // Leading-zero count over the first MAX_LZ+1 bits; MAX_LZ+1 means none found.
    always_comb begin
        lz = LZW'(MAX_LZ + 1);
        for (int i = MAX_LZ; i >= 0; i--) begin
            if (buf_q[i]) begin
                lz = LZW'(i);
            end
        end
    end

    assign one_found = |buf_q[MAX_LZ:0];
    assign exp_form  = (mode_q == MODE_UE) || (mode_q == MODE_SE) ||
                       ((mode_q == MODE_TE) && (arg_q > 5'd1));

    // Decide codeword length, whether it is complete, and its value.
    // Bits above fill are always zero, so a 1 found in the window is a real bit.
    always_comb begin
        need    = 6'd0;
        dec_go  = 1'b0;
        dec_err = 1'b0;
        if (mode_q == MODE_U) begin
            need = {1'b0, arg_q};
        end else if (!exp_form) begin
            need = 6'd1;
        end else begin
            need = 6'({lz, 1'b1});
        end

        if (state_q == DECODE) begin
            if (exp_form) begin
                if (one_found) begin
                    dec_go = ({1'b0, need} <= fill_q);
                end else if (fill_q >= LZ_WINDOW) begin
                    dec_err = 1'b1;
                end
            end else begin
                dec_go = ({1'b0, need} <= fill_q);
            end
        end

        // The top 'need' window bits read as a number: 2^lz + info for
        // Exp-Golomb codes, the raw field for u(n).
        code_val = stream_win >> (WIN_LEN - need);
        ue_val   = OUT_W'(code_val) - ONE;
        se_val   = ue_val[0] ? ((ue_val + ONE) >> 1) : ('0 - (ue_val >> 1));

        dec_value = '0;
        case (mode_q)
            MODE_UE: dec_value = ue_val;
            MODE_SE: dec_value = se_val;
            MODE_TE: dec_value = exp_form ? ue_val : {{(OUT_W-1){1'b0}}, ~buf_q[0]};
            default: dec_value = OUT_W'(code_val);
        endcase
    end

    assign consume_len = dec_go ? need : 6'd0;

    // Next buffer: drop consumed bits, then append a pushed word after what remains.
    always_comb begin
        fill_after = fill_q - {1'b0, consume_len};
        buf_next   = buf_q >> consume_len;
        fill_next  = fill_after;
        if (push) begin
            buf_next  = buf_next | ({{(BUF_BITS-IN_W){1'b0}}, word_rev} << fill_after);
            fill_next = fill_after + IN_W7;
        end
    end

    // Bit buffer and fill count; flush clears exactly like reset.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_next;
            fill_q <= fill_next;
        end
    end

    // Command FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q   <= IDLE;
            mode_q    <= MODE_UE;
            arg_q     <= 5'd0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_len   <= 6'd0;
            res_err   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        mode_q  <= cmd_mode;
                        arg_q   <= cmd_arg;
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_err) begin
                        res_err   <= 1'b1;
                        res_data  <= '0;
                        res_len   <= 6'd0;
                        res_valid <= 1'b1;
                        state_q   <= RESULT;
                    end else if (dec_go) begin
                        res_err   <= 1'b0;
                        res_data  <= dec_value;
                        res_len   <= need;
                        res_valid <= 1'b1;
                        state_q   <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
